// File: rtl/mainfsm.sv
// rtl/mainfsm.sv - multicycle RISC-V main control FSM with memory-ready handshake
//
// Sequences lw, sw, R-type, I-type ALU, beq and jal through fetch, decode,
// execute, memory and writeback. It drives the datapath selects, the write
// enables and the 2-bit ALUOp consumed by the ALU decoder.
//
// Optional build macro: MAINFSM_ILLEGAL_TRAP_EN
//   defined   : an unrecognised opcode in Decode parks the machine in Trap
//               with Illegal=1 until reset is asserted
//   undefined : an unrecognised opcode returns to Fetch as a no-op and
//               Illegal is always 0
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   reset      asynchronous active-low reset
//   op         instruction opcode Instr[6:0], valid from Decode onward
//   MemReady   memory completes the current access this cycle
//   MemReq     memory access request (Fetch, MemRead, MemWrite)
//   IRWrite    load instruction register
//   PCUpdate   unconditional PC write
//   Branch     conditional PC write (qualified by Zero downstream)
//   RegWrite   register file write enable
//   MemWrite   data memory write enable
//   AdrSrc     memory address select: 0 = PC, 1 = ALU result register
//   ALUSrcA    00 = PC, 01 = OldPC, 10 = rs1 data
//   ALUSrcB    00 = rs2 data, 01 = ImmExt, 10 = constant 4
//   ResultSrc  00 = ALUOut, 01 = read data, 10 = ALU result
//   ALUOp      00 = add, 01 = subtract, 10 = decode funct fields
//   Illegal    illegal-opcode flag

module mainfsm (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic       MemReady,
   output logic       MemReq,
   output logic       IRWrite,
   output logic       PCUpdate,
   output logic       Branch,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       AdrSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUOp,
   output logic       Illegal
);

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
`ifdef MAINFSM_ILLEGAL_TRAP_EN
      , S_TRAP   = 4'd11
`endif
   } state_t;

   // Registered per-state control word. The fetch bit marks the Fetch state;
   // IRWrite/PCUpdate there are qualified by the live MemReady below.
   typedef struct packed {
      logic       memreq;
      logic       fetch;
      logic       pcupdate;
      logic       branch;
      logic       regwrite;
      logic       memwrite;
      logic       adrsrc;
      logic [1:0] alusrca;
      logic [1:0] alusrcb;
      logic [1:0] resultsrc;
      logic [1:0] aluop;
      logic       illegal;
   } ctl_t;

   function automatic ctl_t state_ctl(input state_t s);
      ctl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.memreq    = 1'b1;
            c.fetch     = 1'b1;
            c.alusrcb   = 2'b10;
            c.resultsrc = 2'b10;
         end
         S_DECODE: begin
            c.alusrca = 2'b01;
            c.alusrcb = 2'b01;
         end
         S_MEMADR: begin
            c.alusrca = 2'b10;
            c.alusrcb = 2'b01;
         end
         S_MEMREAD: begin
            c.memreq = 1'b1;
            c.adrsrc = 1'b1;
         end
         S_MEMWB: begin
            c.resultsrc = 2'b01;
            c.regwrite  = 1'b1;
         end
         S_MEMWRITE: begin
            c.memreq   = 1'b1;
            c.adrsrc   = 1'b1;
            c.memwrite = 1'b1;
         end
         S_EXECR: begin
            c.alusrca = 2'b10;
            c.aluop   = 2'b10;
         end
         S_EXECI: begin
            c.alusrca = 2'b10;
            c.alusrcb = 2'b01;
            c.aluop   = 2'b10;
         end
         S_ALUWB: begin
            c.regwrite = 1'b1;
         end
         S_BEQ: begin
            c.alusrca = 2'b10;
            c.aluop   = 2'b01;
            c.branch  = 1'b1;
         end
         S_JAL: begin
            c.alusrca  = 2'b01;
            c.alusrcb  = 2'b10;
            c.pcupdate = 1'b1;
         end
`ifdef MAINFSM_ILLEGAL_TRAP_EN
         S_TRAP: begin
            c.illegal = 1'b1;
         end
`endif
         default: c = '0;
      endcase
      return c;
   endfunction

   localparam ctl_t FETCH_CTL = '{memreq: 1'b1, fetch: 1'b1, pcupdate: 1'b0,
                                  branch: 1'b0, regwrite: 1'b0, memwrite: 1'b0,
                                  adrsrc: 1'b0, alusrca: 2'b00, alusrcb: 2'b10,
                                  resultsrc: 2'b10, aluop: 2'b00, illegal: 1'b0};

   state_t state;
   state_t nxt;
   ctl_t   ctl;

   always_comb begin
      nxt = S_FETCH;
      case (state)
         S_FETCH:    nxt = MemReady ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: nxt = S_MEMADR;
               OP_R:         nxt = S_EXECR;
               OP_I:         nxt = S_EXECI;
               OP_BEQ:       nxt = S_BEQ;
               OP_JAL:       nxt = S_JAL;
`ifdef MAINFSM_ILLEGAL_TRAP_EN
               default:      nxt = S_TRAP;
`else
               default:      nxt = S_FETCH;
`endif
            endcase
         end
         S_MEMADR:   nxt = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  nxt = MemReady ? S_MEMWB : S_MEMREAD;
         S_MEMWB:    nxt = S_FETCH;
         S_MEMWRITE: nxt = MemReady ? S_FETCH : S_MEMWRITE;
         S_EXECR:    nxt = S_ALUWB;
         S_EXECI:    nxt = S_ALUWB;
         S_ALUWB:    nxt = S_FETCH;
         S_BEQ:      nxt = S_FETCH;
         S_JAL:      nxt = S_ALUWB;
`ifdef MAINFSM_ILLEGAL_TRAP_EN
         S_TRAP:     nxt = S_TRAP;
`endif
         default:    nxt = S_FETCH;
      endcase
   end

   // The control word is computed from the next state so the outputs come
   // straight from flops yet still match the state being entered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_FETCH;
         ctl   <= FETCH_CTL;
      end else begin
         state <= nxt;
         ctl   <= state_ctl(nxt);
      end
   end

   // Enables are masked by reset so nothing writes while it is held low,
   // even though the control word already shows Fetch selects.
   assign MemReq    = ctl.memreq & reset;
   assign IRWrite   = ctl.fetch & MemReady & reset;
   assign PCUpdate  = ((ctl.fetch & MemReady) | ctl.pcupdate) & reset;
   assign Branch    = ctl.branch & reset;
   assign RegWrite  = ctl.regwrite & reset;
   assign MemWrite  = ctl.memwrite & reset;
   assign AdrSrc    = ctl.adrsrc;
   assign ALUSrcA   = ctl.alusrca;
   assign ALUSrcB   = ctl.alusrcb;
   assign ResultSrc = ctl.resultsrc;
   assign ALUOp     = ctl.aluop;
   assign Illegal   = ctl.illegal & reset;

endmodule

// File: tb/tb_mainfsm.sv
// tb/tb_mainfsm.sv - scoreboard testbench for mainfsm

module tb_mainfsm;

   logic       clk;
   logic       reset;
   logic [6:0] op;
   logic       MemReady;
   logic       MemReq, IRWrite, PCUpdate, Branch, RegWrite, MemWrite, AdrSrc, Illegal;
   logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUOp;

   mainfsm dut (
      .clk(clk), .reset(reset), .op(op), .MemReady(MemReady),
      .MemReq(MemReq), .IRWrite(IRWrite), .PCUpdate(PCUpdate), .Branch(Branch),
      .RegWrite(RegWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
      .ALUOp(ALUOp), .Illegal(Illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {MemReq,IRWrite,PCUpdate,Branch,RegWrite,MemWrite,AdrSrc,A[2],B[2],Res[2],ALUOp[2],Illegal}
   logic [15:0] act;
   assign act = {MemReq, IRWrite, PCUpdate, Branch, RegWrite, MemWrite, AdrSrc,
                 ALUSrcA, ALUSrcB, ResultSrc, ALUOp, Illegal};

   localparam logic [15:0] V_RST   = 16'b0_0_0_0_0_0_0_00_10_10_00_0;
   localparam logic [15:0] V_FR    = 16'b1_1_1_0_0_0_0_00_10_10_00_0;
   localparam logic [15:0] V_FW    = 16'b1_0_0_0_0_0_0_00_10_10_00_0;
   localparam logic [15:0] V_DEC   = 16'b0_0_0_0_0_0_0_01_01_00_00_0;
   localparam logic [15:0] V_MADR  = 16'b0_0_0_0_0_0_0_10_01_00_00_0;
   localparam logic [15:0] V_MRD   = 16'b1_0_0_0_0_0_1_00_00_00_00_0;
   localparam logic [15:0] V_MWB   = 16'b0_0_0_0_1_0_0_00_00_01_00_0;
   localparam logic [15:0] V_MWR   = 16'b1_0_0_0_0_1_1_00_00_00_00_0;
   localparam logic [15:0] V_EXR   = 16'b0_0_0_0_0_0_0_10_00_00_10_0;
   localparam logic [15:0] V_EXI   = 16'b0_0_0_0_0_0_0_10_01_00_10_0;
   localparam logic [15:0] V_AWB   = 16'b0_0_0_0_1_0_0_00_00_00_00_0;
   localparam logic [15:0] V_BEQ   = 16'b0_0_0_1_0_0_0_10_00_00_01_0;
   localparam logic [15:0] V_JAL   = 16'b0_0_1_0_0_0_0_01_10_00_00_0;
   localparam logic [15:0] V_TRAP  = 16'b0_0_0_0_0_0_0_00_00_00_00_1;

   localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
   localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
   localparam logic [6:0] BAD = 7'b1111111;

   typedef struct {
      logic [15:0] v;
      string       n;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   // Monitor: one output vector per cycle, sampled mid-cycle.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         total++;
         if (act !== e.v) begin
            bad++;
            $display("FAIL %s: got %b want %b", e.n, act, e.v);
         end
      end
   end

   // Drive inputs for one cycle and queue the outputs expected in that cycle.
   task automatic step(input logic r, input logic [6:0] o, input logic mr,
                       input logic [15:0] e, input string nm);
      reset    = r;
      op       = o;
      MemReady = mr;
      sb.push_back('{v: e, n: nm});
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; op = 7'd0; MemReady = 1'b1;
      @(posedge clk);
      #1;
      step(0, 7'd0, 1, V_RST, "reset_hold");
      step(1, 7'd0, 0, V_FW,  "fetch_wait");
      step(1, LW,   1, V_FR,  "lw_fetch");
      step(1, LW,   0, V_DEC, "lw_decode_ignores_ready");
      step(1, LW,   1, V_MADR,"lw_memadr");
      step(1, LW,   0, V_MRD, "lw_memread_wait");
      step(1, LW,   1, V_MRD, "lw_memread");
      step(1, LW,   1, V_MWB, "lw_memwb");
      step(1, SW,   1, V_FR,  "sw_fetch");
      step(1, SW,   1, V_DEC, "sw_decode");
      step(1, SW,   1, V_MADR,"sw_memadr");
      for (int i = 0; i < 3; i++) step(1, SW, 0, V_MWR, "sw_memwrite_wait");
      step(1, SW,   1, V_MWR, "sw_memwrite_done");
      step(1, RT,   1, V_FR,  "r_fetch");
      step(1, RT,   1, V_DEC, "r_decode");
      step(1, RT,   0, V_EXR, "r_exec");
      step(1, RT,   1, V_AWB, "r_aluwb");
      step(1, IT,   1, V_FR,  "i_fetch");
      step(1, IT,   1, V_DEC, "i_decode");
      step(1, IT,   1, V_EXI, "i_exec");
      step(1, IT,   1, V_AWB, "i_aluwb");
      step(1, BQ,   1, V_FR,  "beq_fetch");
      step(1, BQ,   1, V_DEC, "beq_decode");
      step(1, BQ,   1, V_BEQ, "beq_branch");
      step(1, JL,   1, V_FR,  "beq_back_to_fetch");
      step(1, JL,   0, V_DEC, "jal_decode");
      step(1, JL,   1, V_JAL, "jal_pcupdate");
      step(1, JL,   1, V_AWB, "jal_aluwb");
      // Reset asserted as ExecuteR begins; no RegWrite may follow.
      step(1, RT,   1, V_FR,  "rst_r_fetch");
      step(1, RT,   1, V_DEC, "rst_r_decode");
      step(0, RT,   1, V_RST, "rst_mid_execr");
      step(0, RT,   1, V_RST, "rst_held");
      step(1, RT,   1, V_FR,  "rst_release_fetch");
      step(1, BAD,  1, V_DEC, "bad_decode");
`ifdef MAINFSM_ILLEGAL_TRAP_EN
      for (int i = 0; i < 12; i++) step(1, BAD, i[0], V_TRAP, "trap_held");
      step(0, BAD,  1, V_RST, "trap_reset");
      step(1, LW,   1, V_FR,  "trap_release_fetch");
`else
      step(1, BAD,  1, V_FR,  "bad_noop_fetch");
      step(1, BAD,  1, V_DEC, "bad_noop_decode");
      step(1, BAD,  0, V_FW,  "bad_noop_fetch_wait");
`endif
      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() > 0) begin
         bad++;
         total++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
